rib_mem: RTL and testbench

Parametrised single-port on-chip memory slave for the RIB bus, replacing the fixed-size, combinational-read ROM. Adds configurable width/depth, byte-lane write strobes, programmable wait states, a read-only mode and error reporting for out-of-range or misaligned accesses. Sits behind the RIB interconnect as the instruction ROM (read-only mode) or data RAM (writable mode).

---
 rtl/rib_mem_pkg.sv | 12 +
 rtl/rib_if.sv | 18 +
 rtl/rib_mem_mem_sp_be.sv | 22 ++
 rtl/rib_mem.sv | 83 ++++++++
 tb/tb_rib_mem.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/rib_mem_pkg.sv
// rib_mem_pkg: shared RIB bus levels, widths, FSM states and helpers
package rib_mem_pkg;
  localparam logic RIB_REQ = 1'b1;
  localparam logic RIB_ACK = 1'b1;
  localparam logic RST_ENABLE = 1'b1;
  localparam logic [31:0] ZERO_WORD = 32'h0;
  localparam int BUS_ADDR_W = 32;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  function automatic int addr_w(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/rib_if.sv
// rib_if: RIB slave-side request/response bundle
interface rib_if
  import rib_mem_pkg::*;
#(
  parameter int DATA_W = 32
) ();
  logic req_i;
  logic we_i;
  logic [BUS_ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] data_i;
  logic [DATA_W/8-1:0] sel_i;
  logic [DATA_W-1:0] data_o;
  logic ack_o;
  logic err_o;
  logic busy_o;
  modport master (output req_i, we_i, addr_i, data_i, sel_i, input data_o, ack_o, err_o, busy_o);
  modport slave (input req_i, we_i, addr_i, data_i, sel_i, output data_o, ack_o, err_o, busy_o);
endinterface

// File: rtl/rib_mem_mem_sp_be.sv
// mem_sp_be: single-port array with per-byte write enables and synchronous read
module mem_sp_be #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 4096,
  parameter int ADDR_W = 12
) (
  input  logic clk,
  input  logic we,
  input  logic re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0] q
);
  logic [DATA_W-1:0] mem [DEPTH];
  // byte-lane writes and registered read; contents deliberately not reset
  always_ff @(posedge clk) begin
    for (int k = 0; k < DATA_W/8; k++)
      if (we && be[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
    if (re) q <= mem[addr];
  end
endmodule

// File: rtl/rib_mem.sv
// rib_mem: RIB memory slave with wait states, byte strobes, ROM mode and error reporting
module rib_mem
  import rib_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH = 4096,
  parameter int WAIT_CYCLES = 0,
  parameter bit WRITABLE = 1'b1
) (
  input logic clk,
  input logic rst,
  rib_if.slave bus
);
  localparam int NB = DATA_W/8;
  localparam int OFF_W = $clog2(NB);
  localparam int ADDR_W = addr_w(DEPTH);
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);
  state_t state;
  logic [3:0] cnt;
  logic l_we, c_we;
  logic [BUS_ADDR_W-1:0] l_addr, c_addr, idx;
  logic [DATA_W-1:0] l_data, c_data, q;
  logic [NB-1:0] l_sel, c_sel;
  logic bad, go_resp, mem_we, mem_re, hide;
  // live request in IDLE lets a zero-wait access commit on its accept edge; latched copy otherwise
  always_comb begin
    c_we = state == S_IDLE ? bus.we_i : l_we;
    c_addr = state == S_IDLE ? bus.addr_i : l_addr;
    c_data = state == S_IDLE ? bus.data_i : l_data;
    c_sel = state == S_IDLE ? bus.sel_i : l_sel;
    idx = c_addr >> OFF_W;
    bad = idx >= BUS_ADDR_W'(DEPTH) || (c_addr & BUS_ADDR_W'(NB-1)) != '0 || (c_we && !WRITABLE);
    go_resp = (state == S_IDLE && bus.req_i == RIB_REQ && WAIT_CYCLES == 0) || (state == S_WAIT && cnt == 4'd1);
    mem_we = go_resp && !bad && c_we && rst != RST_ENABLE;
    mem_re = go_resp && !bad && !c_we && rst != RST_ENABLE;
  end
  mem_sp_be #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk(clk),
    .we(mem_we),
    .re(mem_re),
    .addr(idx[ADDR_W-1:0]),
    .wdata(c_data),
    .be(c_sel),
    .q(q)
  );
  // hide masks the array output after reset and errors; writes leave the previous read visible
  assign bus.data_o = hide ? DATA_W'(ZERO_WORD) : q;
  // request FSM with registered ack/err/busy
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state <= S_IDLE;
      cnt <= '0;
      bus.ack_o <= ~RIB_ACK;
      bus.err_o <= 1'b0;
      bus.busy_o <= 1'b0;
      hide <= 1'b1;
    end else begin
      bus.ack_o <= go_resp ? RIB_ACK : ~RIB_ACK;
      bus.err_o <= go_resp && bad;
      if (go_resp) hide <= bad || (hide && c_we);
      case (state)
        S_IDLE: if (bus.req_i == RIB_REQ) begin
          l_we <= bus.we_i;
          l_addr <= bus.addr_i;
          l_data <= bus.data_i;
          l_sel <= bus.sel_i;
          cnt <= WC;
          bus.busy_o <= 1'b1;
          state <= WAIT_CYCLES == 0 ? S_RESP : S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= S_RESP;
        end
        S_RESP: begin
          bus.busy_o <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rib_mem.sv
// tb_rib_mem: directed checks over four rib_mem configurations
module tb_rib_mem;
  localparam int WC [4] = '{0, 3, 2, 0};
  localparam bit WR [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  logic clk = 1'b0;
  logic rst = 1'b1;
  int dut = 0;
  logic req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0] sel = '0;
  logic [3:0] ack_v, err_v, busy_v;
  logic [31:0] rdat_v [4];
  logic ack, err, busy;
  logic [31:0] rdat;
  int total = 0, bad = 0;
  rib_if #(.DATA_W(32)) bus [4] ();
  always #5 clk = ~clk;
  for (genvar i = 0; i < 4; i++) begin : g_dut
    assign bus[i].req_i = req && dut == i;
    assign bus[i].we_i = we;
    assign bus[i].addr_i = addr;
    assign bus[i].data_i = wdata;
    assign bus[i].sel_i = sel;
    assign ack_v[i] = bus[i].ack_o;
    assign err_v[i] = bus[i].err_o;
    assign busy_v[i] = bus[i].busy_o;
    assign rdat_v[i] = bus[i].data_o;
    rib_mem #(.DATA_W(32), .DEPTH(4096), .WAIT_CYCLES(WC[i]), .WRITABLE(WR[i])) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus[i])
    );
  end
  assign ack = ack_v[dut];
  assign err = err_v[dut];
  assign busy = busy_v[dut];
  assign rdat = rdat_v[dut];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic xact(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] s, output logic [31:0] rd, output logic e, output int lat);
    @(negedge clk);
    dut = d; req = 1'b1; we = w; addr = a; wdata = wd; sel = s;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!ack && lat < 40);
    req = 1'b0;
    rd = rdat;
    e = err;
    if (!ack) chk("ack_timeout", 32'(lat), 32'd0);
    step();
  endtask
  logic [31:0] rd, v0;
  logic e;
  int lat;
  logic [5:0] ab, bb;
  logic seen;
  initial begin
    repeat (3) step();
    chk("rst_ack", 32'(ack_v), 32'h0);
    chk("rst_err", 32'(err_v), 32'h0);
    chk("rst_busy", 32'(busy_v), 32'h0);
    chk("rst_data0", rdat_v[0], 32'h0);
    @(negedge clk) rst = 1'b0;
    xact(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, rd, e, lat);
    chk("w0_lat", 32'(lat), 32'd1);
    chk("w0_err", 32'(e), 32'd0);
    xact(0, 0, 32'h10, 32'h0, 4'h0, rd, e, lat);
    chk("r0_lat", 32'(lat), 32'd1);
    chk("r0_data", rd, 32'hDEADBEEF);
    chk("r0_err", 32'(e), 32'd0);
    xact(0, 1, 32'h10, 32'h000000AA, 4'h1, rd, e, lat);
    chk("wb_err", 32'(e), 32'd0);
    chk("wb_hold", rd, 32'hDEADBEEF);
    xact(0, 0, 32'h10, 32'h0, 4'h0, rd, e, lat);
    chk("rb_data", rd, 32'hDEADBEAA);
    xact(0, 1, 32'h10, 32'h12345678, 4'h0, rd, e, lat);
    chk("wnop_err", 32'(e), 32'd0);
    xact(0, 0, 32'h10, 32'h0, 4'h0, rd, e, lat);
    chk("rnop_data", rd, 32'hDEADBEAA);
    xact(0, 1, 32'h3FFC, 32'hCAFEF00D, 4'hF, rd, e, lat);
    chk("wlast_err", 32'(e), 32'd0);
    xact(0, 0, 32'h3FFC, 32'h0, 4'h0, rd, e, lat);
    chk("rlast_data", rd, 32'hCAFEF00D);
    xact(0, 0, 32'h4000, 32'h0, 4'h0, rd, e, lat);
    chk("oob_err", 32'(e), 32'd1);
    chk("oob_data", rd, 32'h0);
    chk("oob_lat", 32'(lat), 32'd1);
    xact(0, 0, 32'h2, 32'h0, 4'h0, rd, e, lat);
    chk("mis_err", 32'(e), 32'd1);
    chk("mis_data", rd, 32'h0);
    @(negedge clk);
    dut = 1; req = 1'b1; we = 1'b0; addr = 32'h0;
    step();
    req = 1'b0;
    for (int c = 0; c < 6; c++) begin
      ab[c] = ack;
      bb[c] = busy;
      step();
    end
    chk("w3_ack_shape", 32'(ab), 32'h08);
    chk("w3_busy_shape", 32'(bb), 32'h0F);
    xact(1, 1, 32'h40, 32'h0BADF00D, 4'hF, rd, e, lat);
    chk("w3_wlat", 32'(lat), 32'd4);
    xact(1, 0, 32'h40, 32'h0, 4'h0, rd, e, lat);
    chk("w3_rlat", 32'(lat), 32'd4);
    chk("w3_data", rd, 32'h0BADF00D);
    xact(3, 0, 32'h0, 32'h0, 4'h0, rd, e, lat);
    v0 = rd;
    chk("rom_r_err", 32'(e), 32'd0);
    xact(3, 1, 32'h0, 32'h5A5A5A5A, 4'hF, rd, e, lat);
    chk("rom_w_err", 32'(e), 32'd1);
    chk("rom_w_data", rd, 32'h0);
    xact(3, 0, 32'h0, 32'h0, 4'h0, rd, e, lat);
    chk("rom_keep", rd, v0);
    chk("rom_r2_err", 32'(e), 32'd0);
    xact(2, 1, 32'h20, 32'h11223344, 4'hF, rd, e, lat);
    chk("w2_lat", 32'(lat), 32'd3);
    @(negedge clk);
    dut = 2; req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h55667788; sel = 4'hF;
    step();
    req = 1'b0;
    chk("abort_busy", 32'(busy), 32'd1);
    @(negedge clk) rst = 1'b1;
    step();
    chk("abort_ack", 32'(ack), 32'd0);
    chk("abort_busy0", 32'(busy), 32'd0);
    chk("abort_rst_d0", rdat_v[0], 32'h0);
    @(negedge clk) rst = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      step();
      seen |= ack;
    end
    chk("abort_noack", 32'(seen), 32'd0);
    xact(2, 0, 32'h20, 32'h0, 4'h0, rd, e, lat);
    chk("abort_keep", rd, 32'h11223344);
    @(negedge clk);
    dut = 2; req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h99999999; sel = 4'hF;
    step();
    req = 1'b0;
    step();
    @(negedge clk) rst = 1'b1;
    step();
    chk("commit_rst_ack", 32'(ack), 32'd0);
    @(negedge clk) rst = 1'b0;
    xact(2, 0, 32'h20, 32'h0, 4'h0, rd, e, lat);
    chk("commit_rst_keep", rd, 32'h11223344);
    @(negedge clk);
    dut = 2; req = 1'b1; we = 1'b0; addr = 32'h20; sel = 4'h0;
    step();
    addr = 32'h4000; we = 1'b1; wdata = 32'h0; sel = 4'hF; req = 1'b0;
    chk("tog_ack1", 32'(ack), 32'd0);
    @(negedge clk) req = 1'b1;
    step();
    chk("tog_ack2", 32'(ack), 32'd0);
    step();
    chk("tog_ack", 32'(ack), 32'd1);
    chk("tog_err", 32'(err), 32'd0);
    chk("tog_data", rdat, 32'h11223344);
    step();
    req = 1'b0;
    seen = ack;
    repeat (4) begin
      step();
      seen |= ack | busy;
    end
    chk("tog_single_ack", 32'(seen), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
